uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 12 +
 rtl/rr_pick.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 140 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared FSM state type and default sizing for the UART transmit arbiter.
package uart_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_t;

   localparam int UART_ARB_NUM_REQ_DEF        = 3;
   localparam int UART_ARB_TIMEOUT_CYCLES_DEF = 4096;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: one-hot first set request after last_owner, wrapping; purely combinational.
module rr_pick #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_owner,
   output logic [NUM_REQ-1:0] pick,
   output logic               found
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = last_owner;
      // k runs 1..NUM_REQ so the previous owner is searched last
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IDX_W'((int'(last_owner) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Locks the UART byte transmitter to one requester per message, round-robin; grant 1 cycle after request, data path combinational.
// tx_ready passes straight to the owner's req_ready; optional stall watchdog under `UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = UART_ARB_NUM_REQ_DEF,
   parameter int TIMEOUT_CYCLES = UART_ARB_TIMEOUT_CYCLES_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]   req_last,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic                 tx_valid,
   output logic [7:0]           tx_data,
   input  logic                 tx_ready,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 busy,
   output logic                 timeout_pulse
);

   localparam int IDX_W = $clog2(NUM_REQ);

   arb_state_t         state, state_nxt;
   logic [NUM_REQ-1:0] grant_q, grant_nxt;
   logic [IDX_W-1:0]   owner, owner_nxt;
   logic [IDX_W-1:0]   last_owner, last_owner_nxt;
   logic [NUM_REQ-1:0] pick;
   logic               found;
   logic [IDX_W-1:0]   pick_idx;
   logic [7:0]         req_bytes [NUM_REQ];
   logic               xfer;
   logic               msg_done;
   logic               stall_out;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
      assign req_bytes[i] = req_data[8*i +: 8];
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .req        (req_valid),
      .last_owner (last_owner),
      .pick       (pick),
      .found      (found)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) pick_idx = IDX_W'(i);
      end
   end

   assign xfer     = (state == ARB_LOCKED) && req_valid[owner] && tx_ready;
   assign msg_done = xfer && req_last[owner];

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] stall_cnt;

   // Counts locked cycles since the last accepted byte
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (state != ARB_LOCKED || xfer || stall_out) begin
         stall_cnt <= '0;
      end else begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign stall_out = (state == ARB_LOCKED) && !xfer &&
                      (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   // The stall limit only matters with the watchdog built in
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign stall_out          = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ARB_IDLE;
         grant_q    <= '0;
         owner      <= '0;
         last_owner <= IDX_W'(NUM_REQ - 1);
      end else begin
         state      <= state_nxt;
         grant_q    <= grant_nxt;
         owner      <= owner_nxt;
         last_owner <= last_owner_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant_q;
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      case (state)
         ARB_IDLE: begin
            if (found) begin
               state_nxt = ARB_LOCKED;
               grant_nxt = pick;
               owner_nxt = pick_idx;
            end
         end
         ARB_LOCKED: begin
            if (msg_done || stall_out) begin
               state_nxt      = ARB_IDLE;
               grant_nxt      = '0;
               last_owner_nxt = owner;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      tx_valid      = 1'b0;
      tx_data       = 8'h00;
      req_ready     = '0;
      busy          = 1'b0;
      timeout_pulse = 1'b0;
      if (state == ARB_LOCKED) begin
         busy             = 1'b1;
         tx_valid         = req_valid[owner];
         tx_data          = req_bytes[owner];
         req_ready[owner] = tx_ready;
         timeout_pulse    = stall_out;
      end
   end

   assign grant = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized checks of uart_tx_arbiter against a cycle-level message model.
module tb_uart_tx_arbiter;

   localparam int N   = 3;
   localparam int TMO = 16;
`ifdef UART_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic           clk;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic           tx_valid;
   logic [7:0]     tx_data;
   logic           tx_ready;
   logic [N-1:0]   grant;
   logic           busy;
   logic           timeout_pulse;

   uart_tx_arbiter #(
      .NUM_REQ        (N),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .tx_valid      (tx_valid),
      .tx_data       (tx_data),
      .tx_ready      (tx_ready),
      .grant         (grant),
      .busy          (busy),
      .timeout_pulse (timeout_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total, bad;
   // requester message stores: {last, byte}
   logic [8:0] mem [N][64];
   int head [N];
   int tail [N];
   int hold [N];
   int vprob, rdy_mode;
   // behavioural model: current owner (-1 idle), previous owner, stalled cycles
   int m_owner, m_last, m_stall;
   int pulse_cnt, pulse_gap;
   logic [N-1:0] prev_grant;
   int         own_log [$];
   int         exp_own [$];
   logic [7:0] tx_log  [$];
   logic [7:0] exp_log [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_next(input int last, input logic [N-1:0] v);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < N; i++) s += tail[i] - head[i];
      return s;
   endfunction

   task automatic add_msg(input int r, input int len);
      logic [7:0] b;
      for (int k = 0; k < len; k++) begin
         b = 8'($urandom);
         mem[r][tail[r]] = {(k == len - 1), b};
         tail[r]++;
         exp_log.push_back(b);
      end
   endtask

   task automatic clear_logs();
      own_log.delete();
      exp_own.delete();
      tx_log.delete();
      exp_log.delete();
   endtask

   task automatic step();
      int o, w;
      bit xfer, pend, pulse_exp;
      logic [7:0] d_exp;
      @(negedge clk);
      rst = 1'b0;
      case (rdy_mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = ~tx_ready;
         default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      for (int i = 0; i < N; i++) begin
         pend = (head[i] != tail[i]);
         if (hold[i] > 0) begin
            hold[i]--;
            req_valid[i] = 1'b0;
         end else begin
            req_valid[i] = pend && ($urandom_range(0, 99) < vprob);
         end
         req_data[8*i +: 8] = mem[i][head[i]][7:0];
         req_last[i]        = mem[i][head[i]][8];
      end
      #1;
      o         = m_owner;
      xfer      = (o >= 0) ? (req_valid[o] && tx_ready) : 1'b0;
      pulse_exp = TO_EN && (o >= 0) && !xfer && (m_stall + 1 == TMO);
      d_exp     = (o >= 0) ? req_data[8*o +: 8] : 8'h00;
      chk("grant", 32'(grant), (o >= 0) ? (32'd1 << o) : 32'd0);
      chk("busy", 32'(busy), 32'(o >= 0));
      chk("tx_valid", 32'(tx_valid), (o >= 0) ? 32'(req_valid[o]) : 32'd0);
      chk("tx_data", 32'(tx_data), 32'(d_exp));
      chk("req_ready", 32'(req_ready), (o >= 0 && tx_ready) ? (32'd1 << o) : 32'd0);
      chk("timeout_pulse", 32'(timeout_pulse), 32'(pulse_exp));
      if (grant != '0 && prev_grant == '0) begin
         for (int i = 0; i < N; i++) if (grant[i]) own_log.push_back(i);
      end
      prev_grant = grant;
      if (tx_valid && tx_ready) tx_log.push_back(tx_data);
      if (timeout_pulse) begin
         pulse_cnt++;
         pulse_gap = m_stall + 1;
      end
      // what the coming clock edge does, by the message rules
      if (o < 0) begin
         w = rr_next(m_last, req_valid);
         if (w >= 0) m_owner = w;
      end else if (xfer) begin
         m_stall = 0;
         if (mem[o][head[o]][8]) begin
            m_owner = -1;
            m_last  = o;
         end
         head[o]++;
      end else if (pulse_exp) begin
         m_owner = -1;
         m_last  = o;
         m_stall = 0;
      end else begin
         m_stall++;
      end
   endtask

   task automatic drain(input string tag, input int max_cyc);
      for (int n = 0; n < max_cyc && (pending() != 0 || m_owner >= 0); n++) step();
      chk({tag, "_drain"}, 32'(pending()), 32'd0);
      step();
   endtask

   task automatic check_logs(input string tag);
      chk({tag, "_grants"}, 32'(own_log.size()), 32'(exp_own.size()));
      for (int k = 0; k < exp_own.size() && k < own_log.size(); k++)
         chk({tag, "_owner"}, 32'(own_log[k]), 32'(exp_own[k]));
      chk({tag, "_nbytes"}, 32'(tx_log.size()), 32'(exp_log.size()));
      for (int k = 0; k < exp_log.size() && k < tx_log.size(); k++)
         chk({tag, "_byte"}, 32'(tx_log[k]), 32'(exp_log[k]));
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "bench did not finish");
   end

   initial begin
      int h;
      total = 0; bad = 0;
      m_owner = -1; m_last = N - 1; m_stall = 0;
      pulse_cnt = 0; pulse_gap = 0; prev_grant = '0;
      vprob = 100; rdy_mode = 0;
      for (int i = 0; i < N; i++) begin
         head[i] = 0; tail[i] = 0; hold[i] = 0;
         for (int k = 0; k < 64; k++) mem[i][k] = 9'h000;
      end

      // reset with every requester shouting
      rst = 1'b1; tx_ready = 1'b1;
      req_valid = '1; req_data = {N{8'hA5}}; req_last = '1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_timeout", 32'(timeout_pulse), 32'd0);

      // three 2-byte messages: order 0,1,2
      clear_logs();
      for (int i = 0; i < N; i++) add_msg(i, 2);
      exp_own = '{0, 1, 2};
      drain("rr3", 100);
      check_logs("rr3");

      // req 1 five bytes under toggling tx_ready while req 0 waits
      clear_logs();
      rdy_mode = 1; hold[0] = 2;
      add_msg(1, 5);
      add_msg(0, 2);
      exp_own = '{1, 0};
      drain("contig", 100);
      check_logs("contig");

      // lone requester 2, three 1-byte messages back to back
      clear_logs();
      rdy_mode = 2;
      for (int k = 0; k < 3; k++) add_msg(2, 1);
      exp_own = '{2, 2, 2};
      drain("solo", 100);
      check_logs("solo");

      // random rounds
      vprob = 70;
      for (int r = 0; r < 3; r++) begin
         clear_logs();
         for (int i = 0; i < N; i++) begin
            hold[i] = $urandom_range(0, 5);
            add_msg(i, $urandom_range(1, 4));
         end
         drain("rand", 400);
         chk("rand_nbytes", 32'(tx_log.size()), 32'(exp_log.size()));
      end
      vprob = 100; rdy_mode = 0;

      // reset after byte 2 of a 4-byte message
      clear_logs();
      h = tail[1];
      add_msg(1, 4);
      for (int n = 0; n < 50 && head[1] < h + 2; n++) step();
      chk("mid_setup", 32'(head[1] - h), 32'd2);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_grant", 32'(grant), 32'd0);
      chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_req_ready", 32'(req_ready), 32'd0);
      tail[1] = head[1];
      m_owner = -1; m_last = N - 1; m_stall = 0;
      @(posedge clk);
      #1;
      chk("mid_rst_hold_grant", 32'(grant), 32'd0);
      chk("mid_rst_hold_tx_valid", 32'(tx_valid), 32'd0);
      clear_logs();
      for (int i = 0; i < N; i++) add_msg(i, 1);
      exp_own = '{0, 1, 2};
      step();
      step();
      chk("rst_first_grant", 32'(grant), 32'd1);
      drain("after_rst", 100);
      check_logs("after_rst");

      // owner stalls mid-message while req 1 waits
      clear_logs();
      hold[1] = 2;
      h = tail[0];
      add_msg(0, 3);
      add_msg(1, 2);
      for (int n = 0; n < 50 && head[0] < h + 1; n++) step();
      chk("stall_setup", 32'(head[0] - h), 32'd1);
      hold[0] = 40; pulse_cnt = 0; pulse_gap = 0;
      repeat (40) step();
      chk("stall_pulses", 32'(pulse_cnt), TO_EN ? 32'd1 : 32'd0);
      chk("stall_gap", 32'(pulse_gap), TO_EN ? 32'(TMO) : 32'd0);
      chk("stall_grant", 32'(grant), TO_EN ? 32'd0 : 32'd1);
      drain("stall", 200);
      chk("stall_nbytes", 32'(tx_log.size()), 32'(exp_log.size()));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
